sha_sched_ctrl: RTL and testbench
=================================

# sha_sched_ctrl

Sequencing controller for the SHA-256 message schedule. It accepts one 512-bit message block over a valid/ready handshake and computes W[0..ROUNDS-1] with a rolling 16-word window. It streams one schedule word per cycle, with round index, to the compression core over a second valid/ready handshake, and flags block and message completion. It sits between the message-block source (padder/loader) and the round core.

## Interface
- ROUNDS, 64, schedule words emitted per block; legal 17..64
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- blk_valid  in  1  block offered
- blk_ready  out  1  controller can capture a block
- blk_data  in  32 x [16]  message words; [0] = first word (W[0]), big-endian per FIPS 180-4
- blk_last  in  1  block is the final block of the message; sampled with blk_data
- w_valid  out  1  w_data/w_idx valid
- w_ready  in  1  round core consumes the word this cycle
- w_data  out  32  schedule word W[w_idx]
- w_idx  out  6  round index t
- w_last  out  1  high when w_idx == ROUNDS-1
- blk_done  out  1  one-cycle pulse: block fully streamed
- msg_done  out  1  one-cycle pulse: streamed block carried blk_last
- busy  out  1  state != IDLE
- abort  in  1  synchronous abort of the current block

## Operation
- States: IDLE, RUN.
- IDLE: blk_ready = 1. On blk_valid & blk_ready:
  - load win[0..15] <= blk_data[0..15], t <= 0, last_q <= blk_last;
  - go to RUN.
- RUN: w_valid = 1, w_data = win[0], w_idx = t. On each w_valid & w_ready:
  - shift win[k] <= win[k+1] for k = 0..14;
  - win[15] <= ssig1(win[14]) + win[9] + ssig0(win[1]) + win[0], mod 2^32;
  - t <= t+1.
- ssig0(x) = ROTR7 ^ ROTR18 ^ SHR3; ssig1(x) = ROTR17 ^ ROTR19 ^ SHR10. All adds are 32-bit and wrap silently.
- Handshake on t == ROUNDS-1: return to IDLE, pulse blk_done next cycle, and pulse msg_done with it if last_q.
- While w_valid & !w_ready, w_data, w_idx and w_last are held stable; the window does not advance.
- abort in RUN: go to IDLE next edge with w_valid low; no blk_done or msg_done.
  - abort together with the final handshake: abort wins, so no pulses.
  - abort in IDLE: ignored; does not block a simultaneous block capture.
- blk_ready does not depend on w_ready. A block offered during RUN waits.

## Timing
- Reset values:
  - state = IDLE; blk_ready = 0 while rst is high, then 1.
  - w_valid = 0, w_data = 0, w_idx = 0, w_last = 0, blk_done = 0, msg_done = 0, busy = 0.
  - Window and t are cleared.
- Latency:
  - Block captured at edge N; W[0] valid in cycle N+1.
  - With w_ready held high, W[t] is presented in cycle N+1+t.
  - blk_done and msg_done are high in cycle N+1+ROUNDS.
  - blk_ready is high again in that same cycle.
- Throughput: ROUNDS+1 cycles per block (one capture bubble).
- Reset asserted mid-block: all state is cleared immediately; the partial block is discarded; the next block restarts at W[0].

## Structure
- Package sha_pkg holds:
  - typedef sha_word_t (logic [31:0]);
  - SHA_BLOCK_WORDS = 16 and SHA_ROUNDS = 64;
  - the state enum;
  - functions ssig0 and ssig1, shared with the compression core.
- One sub-module: sha_w_window. It contains the 16 x 32 window register, its load/shift enables and the next-word adder.
- sha_sched_ctrl holds the FSM, round counter, last_q flag and done pulses.

## Test plan
- Single "abc" block: blk_data = 61626380, 14 x 00000000, 00000018, blk_last = 1, w_ready = 1.
  - W[0] = 61626380, W[15] = 00000018, W[16] = 61626380, W[17] = 000F0000, W[18] = 7DA86405, W[63] = 12B1EDEB, on the cycles given under Latency.
  - w_last is high only at t = 63.
  - blk_done and msg_done both pulse at N+65.
- Back-to-back blocks, first with blk_last = 0:
  - second block captured the cycle blk_done pulses;
  - msg_done pulses only after the second block.
- Random w_ready stalls (30 % low): the word sequence equals the no-stall run, and w_data/w_idx are stable during every stall.
- abort asserted at t = 20:
  - w_valid is low the next cycle; no done pulses;
  - the following "abc" block streams W[0] = 61626380 correctly.
- rst pulsed asynchronously between edges at t = 40: all outputs go to reset values at once; blk_ready is 1 the first cycle after rst falls.
- abort together with the t = 63 handshake: no blk_done or msg_done; state is IDLE.

Source files
------------

// File: rtl/sha_pkg.sv
// Shared SHA-256 types, sizes and the small-sigma helpers used by the
// message schedule and the compression core.
package sha_pkg;

    localparam int unsigned SHA_WORD_W      = 32;
    localparam int unsigned SHA_BLOCK_WORDS = 16;
    localparam int unsigned SHA_ROUNDS      = 64;
    localparam int unsigned SHA_IDX_W       = 6;

    typedef logic [SHA_WORD_W-1:0] sha_word_t;

    // Element [0] carries W[0], the first big-endian word of the block.
    typedef sha_word_t [SHA_BLOCK_WORDS-1:0] sha_block_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sha_state_t;

    function automatic sha_word_t ssig0(input sha_word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic sha_word_t ssig1(input sha_word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha_sched_ctrl_if.sv
// Block-in / schedule-word-out handshake bundle of the schedule controller.
interface sha_sched_ctrl_if;
    import sha_pkg::*;

    logic                 blk_valid;
    logic                 blk_ready;
    sha_block_t           blk_data;
    logic                 blk_last;
    logic                 w_valid;
    logic                 w_ready;
    sha_word_t            w_data;
    logic [SHA_IDX_W-1:0] w_idx;
    logic                 w_last;
    logic                 blk_done;
    logic                 msg_done;
    logic                 busy;
    logic                 abort;

    // Controller side
    modport master (
        input  blk_valid, blk_data, blk_last, w_ready, abort,
        output blk_ready, w_valid, w_data, w_idx, w_last, blk_done, msg_done, busy
    );

    // Block source / round core side
    modport slave (
        output blk_valid, blk_data, blk_last, w_ready, abort,
        input  blk_ready, w_valid, w_data, w_idx, w_last, blk_done, msg_done, busy
    );

endinterface

// File: rtl/sha_w_window.sv
// Rolling 16-word message-schedule window; w0 is always the word for the
// current round, and each shift appends the next expanded word.
module sha_w_window
    import sha_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       shift,
    input  sha_block_t blk_data,
    output sha_word_t  w0
);

    sha_block_t win_q;
    sha_word_t  next_word_c;

    assign next_word_c = ssig1(win_q[14]) + win_q[9] + ssig0(win_q[1]) + win_q[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q <= '0;
        end else if (load) begin
            win_q <= blk_data;
        end else if (shift) begin
            win_q <= {next_word_c, win_q[SHA_BLOCK_WORDS-1:1]};
        end
    end

    assign w0 = win_q[0];

endmodule

// File: rtl/sha_sched_ctrl.sv
// SHA-256 message-schedule sequencer: captures one block, streams
// W[0..ROUNDS-1] to the round core and flags block/message completion.
module sha_sched_ctrl
    import sha_pkg::*;
#(
    parameter int unsigned ROUNDS = SHA_ROUNDS
) (
    input logic              clk,
    input logic              rst,
    sha_sched_ctrl_if.master bus
);

    localparam logic [SHA_IDX_W-1:0] LAST_IDX = SHA_IDX_W'(ROUNDS - 1);

    sha_state_t           state_q, state_nxt;
    logic [SHA_IDX_W-1:0] t_q, t_nxt;
    logic                 last_q, last_nxt;
    logic                 w_last_q, w_last_nxt;
    logic                 blk_done_q, blk_done_nxt;
    logic                 msg_done_q, msg_done_nxt;
    logic                 blk_ready_q, w_valid_q, busy_q;
    logic                 load_c, shift_c;
    logic                 capture_c, handshake_c, final_c, abort_c;
    sha_word_t            w0;

    assign capture_c   = (state_q == ST_IDLE) && bus.blk_valid && blk_ready_q;
    assign handshake_c = (state_q == ST_RUN) && w_valid_q && bus.w_ready;
    assign final_c     = handshake_c && (t_q == LAST_IDX);
    assign abort_c     = (state_q == ST_RUN) && bus.abort;

    sha_w_window u_window (
        .clk      (clk),
        .rst      (rst),
        .load     (load_c),
        .shift    (shift_c),
        .blk_data (bus.blk_data),
        .w0       (w0)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Abort has priority over the final handshake.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: if (capture_c) state_nxt = ST_RUN;
            ST_RUN:  if (abort_c || final_c) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        load_c       = 1'b0;
        shift_c      = 1'b0;
        t_nxt        = t_q;
        last_nxt     = last_q;
        w_last_nxt   = w_last_q;
        blk_done_nxt = 1'b0;
        msg_done_nxt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (capture_c) begin
                    load_c     = 1'b1;
                    t_nxt      = '0;
                    last_nxt   = bus.blk_last;
                    w_last_nxt = 1'b0;
                end
            end
            ST_RUN: begin
                if (abort_c) begin
                    w_last_nxt = 1'b0;
                end else if (handshake_c) begin
                    shift_c = 1'b1;
                    if (final_c) begin
                        w_last_nxt   = 1'b0;
                        blk_done_nxt = 1'b1;
                        msg_done_nxt = last_q;
                    end else begin
                        t_nxt      = t_q + SHA_IDX_W'(1);
                        w_last_nxt = (t_q + SHA_IDX_W'(1)) == LAST_IDX;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_q         <= '0;
            last_q      <= 1'b0;
            w_last_q    <= 1'b0;
            blk_done_q  <= 1'b0;
            msg_done_q  <= 1'b0;
            blk_ready_q <= 1'b0;
            w_valid_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            t_q         <= t_nxt;
            last_q      <= last_nxt;
            w_last_q    <= w_last_nxt;
            blk_done_q  <= blk_done_nxt;
            msg_done_q  <= msg_done_nxt;
            blk_ready_q <= (state_nxt == ST_IDLE);
            w_valid_q   <= (state_nxt == ST_RUN);
            busy_q      <= (state_nxt != ST_IDLE);
        end
    end

    assign bus.blk_ready = blk_ready_q;
    assign bus.w_valid   = w_valid_q;
    assign bus.w_data    = w0;
    assign bus.w_idx     = t_q;
    assign bus.w_last    = w_last_q;
    assign bus.blk_done  = blk_done_q;
    assign bus.msg_done  = msg_done_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_sha_sched_ctrl.sv
// Randomized bench for sha_sched_ctrl against a FIPS 180-4 schedule model.
module tb_sha_sched_ctrl;
    import sha_pkg::*;

    localparam int ROUNDS = 64;
    typedef sha_word_t wq_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    wq_t  got_w;

    always #5 clk = ~clk;

    sha_sched_ctrl_if bus ();

    sha_sched_ctrl #(.ROUNDS(ROUNDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic sha_word_t rotr(input sha_word_t x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], straight from the standard.
    function automatic wq_t schedule(input wq_t m);
        wq_t w = m;
        for (int t = 16; t < ROUNDS; t++) begin
            sha_word_t s0, s1;
            s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w.push_back(s1 + w[t-7] + s0 + w[t-16]);
        end
        return w;
    endfunction

    function automatic wq_t rand_block();
        wq_t b;
        for (int i = 0; i < 16; i++) b.push_back($urandom);
        return b;
    endfunction

    function automatic wq_t abc_block();
        wq_t b;
        b.push_back(32'h61626380);
        for (int i = 0; i < 14; i++) b.push_back(32'h0);
        b.push_back(32'h00000018);
        return b;
    endfunction

    // Called at a negedge; offers the block and returns just after the capture edge.
    task automatic capture(input wq_t blk, input logic last, input logic with_abort,
                           input string name, output int waited);
        waited = 0;
        bus.blk_valid = 1'b1;
        bus.blk_last  = last;
        bus.abort     = with_abort;
        for (int i = 0; i < 16; i++) bus.blk_data[4'(i)] = blk[i];
        while (bus.blk_ready !== 1'b1) begin
            @(negedge clk);
            waited++;
            if (waited > 200) begin
                n_checks++; n_fail++;
                $display("FAIL %s_capture_timeout: blk_ready never rose", name);
                bus.blk_valid = 1'b0;
                bus.abort = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        bus.blk_valid = 1'b0;
        bus.abort     = 1'b0;
        n_checks++;
        if (bus.w_valid !== 1'b1 || bus.blk_ready !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_capture: got w_valid=%b blk_ready=%b busy=%b expected 1 0 1",
                     name, bus.w_valid, bus.blk_ready, bus.busy);
        end
    endtask

    // Consumes the stream; abort_at >= 0 aborts at that round. Returns at a negedge.
    task automatic stream(input wq_t w, input logic exp_last, input int stall_pct,
                          input int abort_at, input string name);
        int        t = 0;
        int        cyc = 0;
        logic      stalled = 1'b0;
        logic      aborted = 1'b0;
        sha_word_t prev = '0;
        got_w.delete();
        while (t < ROUNDS && !aborted) begin
            @(negedge clk);
            cyc++;
            if (cyc > 4000) begin
                n_checks++; n_fail++;
                $display("FAIL %s_timeout: stuck at t=%0d", name, t);
                bus.w_ready = 1'b0;
                return;
            end
            n_checks++;
            if (bus.w_valid !== 1'b1 || bus.w_idx !== 6'(t) || bus.w_data !== w[t] ||
                bus.w_last !== logic'(t == ROUNDS - 1) || bus.blk_done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_word: got valid=%b idx=%0d data=%h last=%b done=%b expected 1 idx=%0d data=%h last=%b done=0",
                         name, bus.w_valid, bus.w_idx, bus.w_data, bus.w_last, bus.blk_done,
                         t, w[t], t == ROUNDS - 1);
            end
            if (stalled) begin
                n_checks++;
                if (bus.w_data !== prev) begin
                    n_fail++;
                    $display("FAIL %s_stall_hold: got %h expected %h", name, bus.w_data, prev);
                end
            end
            prev = bus.w_data;
            if (t == abort_at) begin
                bus.abort   = 1'b1;
                bus.w_ready = 1'b1;
                @(negedge clk);
                bus.abort   = 1'b0;
                bus.w_ready = 1'b0;
                n_checks++;
                if (bus.w_valid !== 1'b0 || bus.blk_done !== 1'b0 || bus.msg_done !== 1'b0 ||
                    bus.busy !== 1'b0 || bus.blk_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s_abort: got valid=%b done=%b msg=%b busy=%b ready=%b expected 0 0 0 0 1",
                             name, bus.w_valid, bus.blk_done, bus.msg_done, bus.busy, bus.blk_ready);
                end
                aborted = 1'b1;
            end else begin
                stalled = ($urandom_range(99) < stall_pct);
                bus.w_ready = !stalled;
                if (!stalled) begin
                    got_w.push_back(bus.w_data);
                    t++;
                end
            end
        end
        if (!aborted) begin
            @(negedge clk);
            bus.w_ready = 1'b0;
            n_checks++;
            if (bus.blk_done !== 1'b1 || bus.msg_done !== exp_last || bus.blk_ready !== 1'b1 ||
                bus.w_valid !== 1'b0 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_done: got done=%b msg=%b ready=%b valid=%b busy=%b expected 1 %b 1 0 0",
                         name, bus.blk_done, bus.msg_done, bus.blk_ready, bus.w_valid, bus.busy, exp_last);
            end
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (bus.blk_ready !== 1'b0 || bus.w_valid !== 1'b0 || bus.w_data !== 32'h0 ||
            bus.w_idx !== 6'd0 || bus.w_last !== 1'b0 || bus.blk_done !== 1'b0 ||
            bus.msg_done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: got ready=%b valid=%b data=%h idx=%0d last=%b done=%b msg=%b busy=%b expected all 0",
                     bus.blk_ready, bus.w_valid, bus.w_data, bus.w_idx, bus.w_last,
                     bus.blk_done, bus.msg_done, bus.busy);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.blk_ready !== 1'b1 || bus.busy !== 1'b0 || bus.w_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got ready=%b busy=%b valid=%b expected 1 0 0",
                     bus.blk_ready, bus.busy, bus.w_valid);
        end
    endtask

    task automatic test_abc();
        int waited;
        wq_t w = schedule(abc_block());
        capture(abc_block(), 1'b1, 1'b0, "abc", waited);
        stream(w, 1'b1, 0, -1, "abc");
        n_checks++;
        if (got_w.size() != ROUNDS || got_w[0] !== 32'h61626380 || got_w[15] !== 32'h00000018 ||
            got_w[16] !== 32'h61626380 || got_w[17] !== 32'h000F0000 ||
            got_w[18] !== 32'h7DA86405 || got_w[63] !== 32'h12B1EDEB) begin
            n_fail++;
            $display("FAIL abc_known_words: got n=%0d W0=%h W15=%h W16=%h W17=%h W18=%h W63=%h expected 64 61626380 00000018 61626380 000f0000 7da86405 12b1edeb",
                     got_w.size(), got_w[0], got_w[15], got_w[16], got_w[17], got_w[18], got_w[63]);
        end
        @(negedge clk);
        n_checks++;
        if (bus.blk_done !== 1'b0 || bus.msg_done !== 1'b0) begin
            n_fail++;
            $display("FAIL abc_pulse_width: got done=%b msg=%b expected 0 0", bus.blk_done, bus.msg_done);
        end
    endtask

    task automatic test_back_to_back();
        int  waited;
        wq_t a = rand_block();
        wq_t b = rand_block();
        capture(a, 1'b0, 1'b0, "b2b_first", waited);
        stream(schedule(a), 1'b0, 0, -1, "b2b_first");
        // Abort alongside an idle capture must not block it.
        capture(b, 1'b1, 1'b1, "b2b_second", waited);
        n_checks++;
        if (waited != 0) begin
            n_fail++;
            $display("FAIL b2b_no_gap: got %0d wait cycles expected 0", waited);
        end
        stream(schedule(b), 1'b1, 0, -1, "b2b_second");
    endtask

    task automatic test_stall();
        int   waited;
        wq_t  b = rand_block();
        logic last = logic'($urandom_range(1));
        @(negedge clk);
        capture(b, last, 1'b0, "stall", waited);
        stream(schedule(b), last, 30, -1, "stall");
    endtask

    task automatic test_abort();
        int  waited;
        wq_t b = rand_block();
        capture(b, 1'b1, 1'b0, "abort20", waited);
        stream(schedule(b), 1'b1, 0, 20, "abort20");
        @(negedge clk);
        capture(abc_block(), 1'b1, 1'b0, "after_abort", waited);
        stream(schedule(abc_block()), 1'b1, 0, -1, "after_abort");
    endtask

    task automatic test_async_reset();
        int  waited;
        wq_t b = rand_block();
        capture(b, 1'b1, 1'b0, "rst_mid", waited);
        bus.w_ready = 1'b1;
        repeat (41) @(negedge clk);
        n_checks++;
        if (bus.w_idx !== 6'd40 || bus.w_data !== schedule(b)[40]) begin
            n_fail++;
            $display("FAIL rst_mid_progress: got idx=%0d data=%h expected 40 %h",
                     bus.w_idx, bus.w_data, schedule(b)[40]);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (bus.blk_ready !== 1'b0 || bus.w_valid !== 1'b0 || bus.w_data !== 32'h0 ||
            bus.w_idx !== 6'd0 || bus.w_last !== 1'b0 || bus.blk_done !== 1'b0 ||
            bus.msg_done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_clear: got ready=%b valid=%b data=%h idx=%0d last=%b done=%b msg=%b busy=%b expected all 0",
                     bus.blk_ready, bus.w_valid, bus.w_data, bus.w_idx, bus.w_last,
                     bus.blk_done, bus.msg_done, bus.busy);
        end
        #1 rst = 1'b0;
        bus.w_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.blk_ready !== 1'b1 || bus.busy !== 1'b0 || bus.blk_done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_release: got ready=%b busy=%b done=%b expected 1 0 0",
                     bus.blk_ready, bus.busy, bus.blk_done);
        end
        capture(abc_block(), 1'b0, 1'b0, "after_rst", waited);
        stream(schedule(abc_block()), 1'b0, 0, -1, "after_rst");
    endtask

    task automatic test_abort_final();
        int  waited;
        wq_t b = rand_block();
        @(negedge clk);
        capture(b, 1'b1, 1'b0, "abort_final", waited);
        stream(schedule(b), 1'b1, 0, ROUNDS - 1, "abort_final");
        @(negedge clk);
        n_checks++;
        if (bus.blk_done !== 1'b0 || bus.msg_done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_final_quiet: got done=%b msg=%b busy=%b expected 0 0 0",
                     bus.blk_done, bus.msg_done, bus.busy);
        end
    endtask

    initial begin
        bus.blk_valid = 1'b0;
        bus.blk_data  = '0;
        bus.blk_last  = 1'b0;
        bus.w_ready   = 1'b0;
        bus.abort     = 1'b0;
        test_reset();
        test_abc();
        test_back_to_back();
        test_stall();
        test_abort();
        test_async_reset();
        test_abort_final();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
